cp0: RTL

CP0 -- requirements
Module: cp0

---
 rtl/cp0_pkg.sv | 38 +++
 rtl/cp0.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 block.
// Register numbers, exception codes, status/cause field positions, handler address.
// Pure declarations; no logic and no timing.
package cp0_pkg;

  // mfc0/mtc0 register numbers
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_EBASE = 5'd15;

  // Exception codes carried on ExcCodeIn and recorded in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR field positions
  localparam int SR_IM_LO = 10;
  localparam int SR_IM_HI = 15;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  // Exception handler entry point (reset value of EBase)
  localparam logic [31:0] EBASE_RESET = 32'h0000_4180;

  // Low 12 bits of a written EBase are pinned to the handler offset
  localparam logic [11:0] EBASE_OFFSET = 12'h180;

endpackage

// File: rtl/cp0.sv
// cp0: MIPS-style coprocessor 0 holding SR, Cause, EPC (and optionally EBase).
// Ports: clk/reset (sync, active-high); A1/DOut mfc0 read; A2/DIn/WE mtc0 write;
//   PC/DS/ExcCodeIn/HWInt/EXLClr commit-point inputs; Req/EPCOut/EBase to fetch.
// Req and DOut are combinational; register writes land on the next rising edge.
// Optional feature macro: CP0_EBASE_EN adds a writable EBase register at reg 15.
module cp0
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        DS,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] EBase,
  output logic [31:0] DOut
);

  // Architectural state, kept as individual fields so unimplemented bits read 0
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic [31:0] w_ebase;

  assign w_int_req = (|(HWInt & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (ExcCodeIn != EXC_INT) & ~r_sr_exl;
  assign w_req     = (w_int_req | w_exc_req) & ~reset;
  assign Req       = w_req;

  // An mtc0 is dropped when the same instruction is being taken as an exception
  assign w_wr = WE & ~w_req;

  always_comb begin
    w_sr = 32'h0;
    w_sr[SR_IM_HI:SR_IM_LO] = r_sr_im;
    w_sr[SR_EXL]            = r_sr_exl;
    w_sr[SR_IE]             = r_sr_ie;
  end

  always_comb begin
    w_cause = 32'h0;
    w_cause[CAUSE_BD]                  = r_cause_bd;
    w_cause[CAUSE_IP_HI:CAUSE_IP_LO]   = r_cause_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_cause_exc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_im     <= 6'h0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'h0;
      r_cause_exc <= 5'h0;
      r_epc       <= 32'h0;
    end else begin
      // Pending-interrupt view tracks the pins regardless of masking
      r_cause_ip <= HWInt;
      if (w_req) begin
        r_sr_exl    <= 1'b1;
        r_cause_bd  <= DS;
        // Interrupts take priority over a simultaneous synchronous exception
        r_cause_exc <= w_int_req ? EXC_INT : ExcCodeIn;
        r_epc       <= DS ? (PC - 32'd4) : PC;
      end else begin
        if (w_wr && A2 == REG_SR) begin
          r_sr_im  <= DIn[SR_IM_HI:SR_IM_LO];
          r_sr_exl <= DIn[SR_EXL];
          r_sr_ie  <= DIn[SR_IE];
        end
        if (w_wr && A2 == REG_EPC) begin
          r_epc <= DIn;
        end
        // Placed after the SR write so eret's clear overrides the written EXL
        if (EXLClr) begin
          r_sr_exl <= 1'b0;
        end
      end
    end
  end

`ifdef CP0_EBASE_EN
  logic [31:0] r_ebase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ebase <= EBASE_RESET;
    end else if (w_wr && A2 == REG_EBASE) begin
      r_ebase <= {DIn[31:12], EBASE_OFFSET};
    end
  end

  assign w_ebase = r_ebase;
`else
  assign w_ebase = EBASE_RESET;
`endif

  assign EBase  = w_ebase;
  assign EPCOut = r_epc;

  // mfc0 read port: no bypass from a same-cycle mtc0
  always_comb begin
    DOut = 32'h0;
    case (A1)
      REG_SR:    DOut = w_sr;
      REG_CAUSE: DOut = w_cause;
      REG_EPC:   DOut = r_epc;
`ifdef CP0_EBASE_EN
      REG_EBASE: DOut = w_ebase;
`endif
      default:   DOut = 32'h0;
    endcase
  end

endmodule
